// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants for the 1x3 router datapath.
package router_pkg;
   localparam int DATA_W      = 8;
   localparam int FIFO_DEPTH  = 16;
   localparam int FIFO_ADDR_W = 4;
   localparam int PKT_CNT_W   = 7;
   // Header byte layout: payload length lives in bits [LEN_MSB:LEN_LSB].
   localparam int LEN_MSB     = 7;
   localparam int LEN_LSB     = 2;
endpackage

// File: rtl/router_fifo_if.sv
// rtl/router_fifo_if.sv - write/read/flush bundle between router_sync, client and router_fifo.
interface router_fifo_if #(parameter int WIDTH = router_pkg::DATA_W);
   logic             soft_reset;
   logic             write_enb;
   logic             read_enb;
   logic             lfd_state;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;

   modport master (
      output soft_reset, write_enb, read_enb, lfd_state, data_in,
      input  data_out, full, empty
   );

   modport slave (
      input  soft_reset, write_enb, read_enb, lfd_state, data_in,
      output data_out, full, empty
   );
endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-port output buffer; stores header-tagged bytes and tracks the
// remaining length of the packet being read so data_out returns to 0 between packets.
module router_fifo
   import router_pkg::*;
#(
   parameter int WIDTH  = DATA_W,
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input logic         clock,
   input logic         resetn,
   router_fifo_if.slave bus
);

   logic [ADDR_W:0]    r_wr_ptr;
   logic [ADDR_W:0]    r_rd_ptr;
   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [DEPTH-1:0]   r_tag;
   logic [PKT_CNT_W-1:0] r_pkt_cnt;
   logic [WIDTH-1:0]   r_data_out;

   logic               w_full;
   logic               w_empty;
   logic               w_wr_acc;
   logic               w_rd_acc;
   logic               w_rd_tag;
   logic [WIDTH-1:0]   w_rd_data;
   logic [PKT_CNT_W-1:0] w_hdr_cnt;

   assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);

   // Flush outranks both ports in the same cycle.
   assign w_wr_acc = bus.write_enb && !w_full  && !bus.soft_reset;
   assign w_rd_acc = bus.read_enb  && !w_empty && !bus.soft_reset;

   assign w_rd_tag  = r_tag[r_rd_ptr[ADDR_W-1:0]];
   assign w_rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];
   // Payload length plus the trailing parity byte.
   assign w_hdr_cnt = PKT_CNT_W'(w_rd_data[WIDTH-1:LEN_LSB]) + PKT_CNT_W'(1);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pkt_cnt  <= '0;
         r_data_out <= '0;
         r_tag      <= '0;
      end else if (bus.soft_reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pkt_cnt  <= '0;
         r_data_out <= '0;
         r_tag      <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr                     <= r_wr_ptr + (ADDR_W+1)'(1);
            r_tag[r_wr_ptr[ADDR_W-1:0]] <= bus.lfd_state;
         end
         if (w_rd_acc) begin
            r_rd_ptr   <= r_rd_ptr + (ADDR_W+1)'(1);
            r_data_out <= w_rd_data;
            if (w_rd_tag)
               r_pkt_cnt <= w_hdr_cnt;
            else if (r_pkt_cnt != '0)
               r_pkt_cnt <= r_pkt_cnt - PKT_CNT_W'(1);
         end else if (r_pkt_cnt == '0) begin
            r_data_out <= '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_wr_acc)
         r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.data_in;
   end

   assign bus.data_out = r_data_out;
   assign bus.full     = w_full;
   assign bus.empty    = w_empty;

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Output buffer of the 1x3 router. One instance per destination port (three in the top level).
- Sits directly downstream of router_sync:
  - write_enb[i] from router_sync drives this block's write_enb.
  - soft_reset_i from router_sync drives this block's soft_reset.
  - This block's full and empty feed router_sync's full_i and empty_i.
- Stores packet bytes, each tagged with a header marker. Tracks the payload length of the packet being read out so that the read side knows when the packet ends.

Parameters:
- WIDTH, 8, data byte width. Each stored word is WIDTH+1 bits: the lfd tag plus the data byte.
- DEPTH, 16, number of entries. Must be a power of two.
- ADDR_W, 4, log2(DEPTH). Read and write pointers are ADDR_W+1 bits.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous flush from router_sync (read timeout). Active high.
- write_enb  in  1  write request from router_sync.
- read_enb  in  1  read request from the destination client.
- lfd_state  in  1  high while the header byte is being written. Stored as the tag bit of that entry.
- data_in  in  WIDTH  byte to be written.
- data_out  out  WIDTH  registered read data.
- full  out  1  high when the occupancy equals DEPTH.
- empty  out  1  high when the occupancy equals 0.

Behaviour:
- Reset (resetn=0, asynchronous):
  - Pointers are cleared to 0.
  - The packet counter is cleared to 0.
  - data_out is cleared to 0.
  - All tag bits are cleared to 0.
  - Outputs after reset: empty=1, full=0.
- Flags:
  - full is asserted when wr_ptr[ADDR_W] differs from rd_ptr[ADDR_W] and the lower ADDR_W bits of the two pointers are equal.
  - empty is asserted when the two pointers are equal.
  - Both flags are derived combinationally from the registered pointers.
- Write:
  - A write is accepted at a clock edge when write_enb=1 and full=0.
  - The accepted entry is mem[wr_ptr] = {lfd_state, data_in}, and wr_ptr increments.
  - If full=1, the write is silently dropped and the entry is not corrupted.
- Read:
  - A read is accepted at a clock edge when read_enb=1 and empty=0.
  - The read updates data_out = mem[rd_ptr][WIDTH-1:0], and rd_ptr increments.
  - Latency is one cycle: data_out is valid in the cycle after read_enb is sampled.
- Packet counter (7 bits):
  - When the accepted read entry has tag=1 (header), the counter loads data[WIDTH-1:2] + 1, which is the payload length plus the parity byte.
  - When the accepted read entry has tag=0 and the counter is nonzero, the counter decrements by 1.
  - When the counter is 0 and no read is accepted, data_out is driven to 0 on the next edge. This indicates that no packet is in flight.
- Simultaneous read and write:
  - When the FIFO is neither empty nor full, both are accepted and the occupancy is unchanged.
  - When the FIFO is full, the read is accepted and the write is dropped. The dropped write is not retried.
  - When the FIFO is empty, the write is accepted and the read is ignored. There is no bypass.
- Pointer wrap:
  - The pointers wrap naturally at 2*DEPTH.
  - The memory index is ptr[ADDR_W-1:0].
- Soft reset (synchronous, priority over read and write in the same cycle):
  - Clears both pointers and the packet counter.
  - Clears data_out to 0.
  - Clears all tag bits.
  - Result after soft reset: empty=1 on the next cycle.
- Reset mid-packet:
  - resetn deassertion or soft_reset discards every stored byte.
  - No partial-packet state survives.

Decomposition:
- Shared package router_pkg:
  - Constants DATA_W=8, FIFO_DEPTH=16, FIFO_ADDR_W=4, PKT_CNT_W=7.
  - Header field slice constant LEN_MSB=7, LEN_LSB=2.
- This block is a single module; no sub-module is needed.

Test Plan:
- Reset, then idle: empty=1, full=0, data_out=0 → these values hold for 5 cycles.
- Write 16 bytes: header 0x38 with lfd=1 (length 14), then 15 bytes 0x01..0x0F with lfd=0. → full=1 after the 16th write. A 17th write of 0xAA is dropped.
- Read that packet out:
  - data_out = 0x38, then 0x01 through 0x0F in order, each one cycle after read_enb.
  - The counter loads 15 and reaches 0 on the last byte.
  - empty=1 after the 16th read. data_out=0 on the following idle cycle.
- Wrap plus simultaneous access:
  - Prefill 8 bytes, then run read_enb=1 and write_enb=1 together for 20 cycles.
  - Required: occupancy stays at 8, the pointers wrap, and the read data matches a scoreboard.
- Soft reset mid-packet: with 10 bytes stored, pulse soft_reset=1 together with read_enb=1 → empty=1 next cycle, data_out=0, no read occurs.
- Async reset mid-write: drop resetn between clock edges while write_enb=1 → empty=1 and full=0 immediately, without waiting for a clock edge.
